// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 byte demultiplexer (demux_l2).
package demux_pkg;

    localparam int unsigned LANES         = 4;
    localparam int unsigned PTR_W         = 2;
    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [PTR_W-1:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

endpackage

// File: rtl/demux_lane_ptr.sv
// Wrapping 2-bit beat counter: advances on each valid beat, strobes on group completion.
// Optional synchronous clear when DEMUX_FLUSH_EN is defined.
module demux_lane_ptr
    import demux_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      en_i,
`ifdef DEMUX_FLUSH_EN
    input  logic      clr_i,
`endif
    output lane_idx_t ptr_o,
    output logic      done_o
);

    lane_idx_t ptr_q;
    lane_idx_t ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = lane_idx_t'(ptr_q + 1'b1);
        end
`ifdef DEMUX_FLUSH_EN
        // A flush always ends the current group, whether or not a beat came with it.
        if (clr_i) begin
            ptr_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign done_o = en_i && (ptr_q == LAST_LANE);

endmodule

// File: rtl/demux_l2.sv
// Two-level 1:4 byte demultiplexer: stages beats round-robin and releases aligned four-lane groups.
// DEMUX_FLUSH_EN adds a flush input that releases a partial group.
module demux_l2
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             valid_out2,
    output logic             valid_out3,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3
`ifdef DEMUX_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    lane_idx_t        ptr;
    logic             done;

    logic [WIDTH-1:0] stage_q [LANES];
    logic [WIDTH-1:0] dout_q  [LANES];
    logic [WIDTH-1:0] dout_d  [LANES];
    logic [LANES-1:0] valid_q;
    logic [LANES-1:0] valid_d;

    demux_lane_ptr u_ptr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (valid_in),
`ifdef DEMUX_FLUSH_EN
        .clr_i  (flush),
`endif
        .ptr_o  (ptr),
        .done_o (done)
    );

    // The lane under the pointer takes the live beat; the others present their staged byte.
    always_comb begin
        valid_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            dout_d[i] = (valid_in && (lane_idx_t'(i) == ptr)) ? data_in : stage_q[i];
        end
        if (done) begin
            valid_d = '1;
        end
`ifdef DEMUX_FLUSH_EN
        else if (flush) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                valid_d[i] = (lane_idx_t'(i) < ptr) || (valid_in && (lane_idx_t'(i) == ptr));
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                stage_q[i] <= '0;
                dout_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (valid_in && (lane_idx_t'(i) == ptr)) begin
                    stage_q[i] <= data_in;
                end
                if (valid_d[i]) begin
                    dout_q[i] <= dout_d[i];
                end
            end
        end
    end

    assign valid_out0 = valid_q[0];
    assign valid_out1 = valid_q[1];
    assign valid_out2 = valid_q[2];
    assign valid_out3 = valid_q[3];
    assign data_out0  = dout_q[0];
    assign data_out1  = dout_q[1];
    assign data_out2  = dout_q[2];
    assign data_out3  = dout_q[3];

endmodule

// File: tb/tb_demux_l2.sv
// Scoreboard bench for demux_l2: stimulus pushes hand-computed groups, a negedge monitor checks them.
// Define DEMUX_FLUSH_EN for both RTL and bench to exercise the flush cases.
module tb_demux_l2;

    logic       clk;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
`ifdef DEMUX_FLUSH_EN
    logic       flush;
`endif

    demux_l2 #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3)
`ifdef DEMUX_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    typedef struct packed {
        int unsigned     cyc;
        logic [3:0]      mask;
        logic [3:0][7:0] d;
    } exp_t;

    exp_t            sb[$];
    int unsigned     cyc   = 0;
    int              total = 0;
    int              bad   = 0;
    logic [3:0][7:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge checks reset state, a released group, or that data holds.
    always @(negedge clk) begin
        logic [3:0]      vo;
        logic [3:0][7:0] dout;
        exp_t            e;
        logic [3:0][7:0] want;
        vo   = {valid_out3, valid_out2, valid_out1, valid_out0};
        dout = {data_out3, data_out2, data_out1, data_out0};
        if (reset) begin
            held = '0;
            total++;
            if (vo != 4'h0 || dout != '0) begin
                bad++;
                $display("FAIL reset_outs: got valid=%b data=%h want valid=0000 data=0", vo, dout);
            end
        end else if (vo != 4'h0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got valid=%b data=%h at cycle %0d want no pulse", vo, dout, cyc);
            end else begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++) want[i] = e.mask[i] ? e.d[i] : held[i];
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL grp_cycle: got %0d want %0d", cyc, e.cyc);
                end
                total++;
                if (vo != e.mask) begin
                    bad++;
                    $display("FAIL grp_valid: got %b want %b", vo, e.mask);
                end
                total++;
                if (dout != want) begin
                    bad++;
                    $display("FAIL grp_data: got %h want %h", dout, want);
                end
                held = want;
            end
        end else begin
            total++;
            if (dout != held) begin
                bad++;
                $display("FAIL data_hold: got %h want %h at cycle %0d", dout, held, cyc);
            end
        end
    end

    // Expected group released by the edge that ends the current step.
    task automatic expect_grp(input logic [3:0] m, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
        exp_t e;
        e.cyc  = cyc + 1;
        e.mask = m;
        e.d    = {d3, d2, d1, d0};
        sb.push_back(e);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic f);
        valid_in = v;
        data_in  = d;
`ifdef DEMUX_FLUSH_EN
        flush    = f;
`else
        if (f) $display("flush requested without DEMUX_FLUSH_EN");
`endif
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = 8'h00;
`ifdef DEMUX_FLUSH_EN
        flush    = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        held     = '0;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
`ifdef DEMUX_FLUSH_EN
        flush    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Single group
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        expect_grp(4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
        step(1'b1, 8'h44, 1'b0);
        idle(2);

        // Back-to-back groups on continuous valid
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) expect_grp(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
            if (i == 8) expect_grp(4'hF, 8'h05, 8'h06, 8'h07, 8'h08);
            step(1'b1, 8'(i), 1'b0);
        end
        idle(2);

        // Gaps stretch a group
        step(1'b1, 8'hA0, 1'b0);
        idle(3);
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        idle(1);
        expect_grp(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        step(1'b1, 8'hA3, 1'b0);
        idle(2);

        // Async reset mid-group discards partial beats
        step(1'b1, 8'hB0, 1'b0);
        step(1'b1, 8'hB1, 1'b0);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({valid_out3, valid_out2, valid_out1, valid_out0} != 4'h0 ||
            {data_out3, data_out2, data_out1, data_out0} != 32'h0) begin
            bad++;
            $display("FAIL async_reset: got data=%h want 0",
                     {data_out3, data_out2, data_out1, data_out0});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'hC0, 1'b0);
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        expect_grp(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        step(1'b1, 8'hC3, 1'b0);
        idle(2);

`ifdef DEMUX_FLUSH_EN
        // Flush with no beat releases the staged lanes only
        step(1'b1, 8'hD0, 1'b0);
        step(1'b1, 8'hD1, 1'b0);
        expect_grp(4'b0011, 8'hD0, 8'hD1, 8'h00, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hE1, 1'b0);
        step(1'b1, 8'hE2, 1'b0);
        expect_grp(4'hF, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
        step(1'b1, 8'hE3, 1'b0);
        idle(1);

        // Flush at ptr=0 with no beat does nothing
        step(1'b0, 8'h00, 1'b1);
        idle(1);

        // Flush together with a beat releases the partial group including it
        step(1'b1, 8'hF0, 1'b0);
        expect_grp(4'b0011, 8'hF0, 8'hF1, 8'h00, 8'h00);
        step(1'b1, 8'hF1, 1'b1);
        idle(1);

        // Flush with the completing beat is an ordinary group
        step(1'b1, 8'h91, 1'b0);
        step(1'b1, 8'h92, 1'b0);
        step(1'b1, 8'h93, 1'b0);
        expect_grp(4'hF, 8'h91, 8'h92, 8'h93, 8'h94);
        step(1'b1, 8'h94, 1'b1);
        idle(1);
        step(1'b1, 8'h95, 1'b0);
        step(1'b1, 8'h96, 1'b0);
        step(1'b1, 8'h97, 1'b0);
        expect_grp(4'hF, 8'h95, 8'h96, 8'h97, 8'h98);
        step(1'b1, 8'h98, 1'b0);
`endif

        idle(4);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_groups: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_l2.md
# demux_l2

Two-level 1:4 byte demultiplexer that undoes the 4:1 mux tree: takes the serialized byte stream and its valid qualifier and distributes consecutive valid beats round-robin onto four output lanes. It sits at the receive end of the mux tree's output link. It releases one aligned four-lane group per completed set of beats. Single clock domain; lane-rate outputs are qualified by per-lane valids rather than derived clocks.

## Interface
- WIDTH, 8, data width of input and of each output lane
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  data_in carries a beat this cycle
- data_in  input  WIDTH  serialized byte stream
- valid_out0..valid_out3  output  1 each  lane N holds a new byte this cycle
- data_out0..data_out3  output  WIDTH each  lane N byte
- flush  input  1  present only with DEMUX_FLUSH_EN; release a partial group

## Operation
- Lane pointer `ptr` is a 2-bit value, 0..3, reset to 0. It advances by 1, wrapping 3→0, only on clock edges where valid_in=1. Cycles with valid_in=0 are ignored and do not move ptr.
- Beat at ptr=0, 1 or 2: data_in is written to staging register stage[ptr]. Outputs are unchanged and all valid_out are 0.
- Beat at ptr=3: the group completes. data_out0..2 <= stage[0..2] and data_out3 <= data_in. All four valid_out are 1 for exactly one cycle. ptr returns to 0.
- Stream order is fixed: the Nth valid beat after reset (N from 0) lands on lane N mod 4.
- data_outN holds its last value between groups. valid_outN is a single-cycle pulse.
- Staging registers are not cleared after a group; stale contents are never visible without a fresh write.

## Timing
- Reset (async assert, any time) sets:
  - ptr=0
  - stage[0..3]=0
  - data_out0..3=0
  - valid_out0..3=0
- Reset asserted mid-group discards all partial beats. The first beat after reset release is lane 0.
- Latency: the group appears at the output one clock after the edge that samples the ptr=3 beat. Lane 0 data therefore shows up 4 valid beats after it entered.
- Back-to-back groups on continuous valid_in: valid_out pulses every 4th cycle and data_out never stalls. There is no backpressure; downstream must accept every pulse.
- Gaps in valid_in stretch a group arbitrarily. There is no timeout.

## Configuration
- DEMUX_FLUSH_EN defined:
  - The flush port exists.
  - flush=1 with ptr≠0 and valid_in=0: lanes 0..ptr-1 output their staged bytes with valid_out set only for those lanes, one cycle; ptr returns to 0.
  - flush=1 with valid_in=1: the beat is taken first. If that beat completes a group, behaviour is a normal group. Otherwise the partial group including this beat is released, and ptr returns to 0.
  - flush with ptr=0 and valid_in=0: no effect.
- DEMUX_FLUSH_EN undefined: no flush port. Partial groups wait indefinitely for further beats.

## Structure
- Shared package demux_pkg:
  - LANES=4
  - PTR_W=2
  - lane-index typedef lane_idx_t
  - the default WIDTH constant
- Natural sub-module: demux_lane_ptr. It is the wrapping 2-bit beat counter with enable (valid_in), async reset and, under DEMUX_FLUSH_EN, synchronous clear. It outputs ptr and a group-complete strobe.
- Top holds the staging registers, output registers and the flush mask logic.

## Test plan
- Reset then 4 consecutive beats 0x11,0x22,0x33,0x44 → one cycle after the 4th beat: data_out0..3=0x11,0x22,0x33,0x44 and valid_out0..3=1 for 1 cycle, then 0.
- 8 continuous beats 0x01..0x08 → two pulses 4 cycles apart: {01,02,03,04} then {05,06,07,08}. Data holds between pulses.
- Beats 0xA0, gap of 3 idle cycles, 0xA1, 0xA2, gap, 0xA3 → single group {A0,A1,A2,A3}. No valid_out during the gaps.
- Beats 0xB0,0xB1, async reset pulse mid-cycle, then 0xC0..0xC3 → all outputs 0 during reset; group after reset is {C0,C1,C2,C3}, with no B bytes.
- (DEMUX_FLUSH_EN) beats 0xD0,0xD1 then flush with valid_in=0 → valid_out0,1=1 with 0xD0,0xD1 and valid_out2,3=0. The next beat 0xE0 lands on lane 0.
- (DEMUX_FLUSH_EN) flush with ptr=0 and valid_in=0 → no valid_out and ptr stays 0.
